mux_scan_capture: RTL
=====================

MUX_SCAN_CAPTURE -- requirements
Module: mux_scan_capture

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 13, giving the number of mux channels scanned per frame (legal range 2..16).
REQ-002 The block SHALL have parameter SETTLE, default 1, giving the settle cycles after each select change before y is sampled (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request one scan frame.
REQ-006 The block SHALL have port y, input, 1 bit: the mux output for the currently driven select.
REQ-007 The block SHALL have port select, output, 4 bits: the channel index driven to the 13:1 mux.
REQ-008 The block SHALL have port data, output, NUM_CH bits: the captured frame, where data[k] holds the y value sampled while select==k.
REQ-009 The block SHALL have port valid, output, 1 bit: data holds a complete frame.
REQ-010 The block SHALL have port ready, input, 1 bit: the consumer accepts the frame.
REQ-011 The block SHALL have port busy, output, 1 bit: a scan or undelivered frame is in progress.

Function
REQ-012 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and DONE, and all outputs SHALL be registered.
REQ-013 In IDLE, start=1 SHALL move the FSM to SETTLE (or to SAMPLE if SETTLE==0), with select=0, busy=1 and the settle counter cleared.
REQ-014 In SETTLE, the counter SHALL run for exactly SETTLE cycles and the FSM SHALL then enter SAMPLE; select SHALL be held constant throughout.
REQ-015 In SAMPLE, the block SHALL spend one cycle writing y into shadow bit [select]; if select<NUM_CH-1 it SHALL increment select and return to SETTLE (or stay in SAMPLE if SETTLE==0).
REQ-016 When SAMPLE completes with select==NUM_CH-1, the block SHALL copy the shadow register (including the current bit) into data, assert valid and enter DONE.
REQ-017 Latency: valid SHALL rise NUM_CH*(SETTLE+1) clock edges after the edge that accepted start (26 cycles at the defaults, 13 cycles with SETTLE=0).
REQ-018 In DONE, valid and data SHALL be held stable until ready=1; the handshake valid&&ready SHALL clear valid on the same edge and return the FSM to IDLE.
REQ-019 ready SHALL be ignored while valid=0, and start SHALL be ignored in every state other than IDLE, including the cycle in which the handshake occurs.
REQ-020 select SHALL never exceed NUM_CH-1 and SHALL return to 0 on entry to IDLE; no wrap-around beyond NUM_CH-1 SHALL occur.
REQ-021 data SHALL keep the last delivered frame after the handshake until the next frame completes.
REQ-022 busy SHALL be 1 in SETTLE, SAMPLE and DONE, and 0 in IDLE.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, select=0, data=0, shadow=0, valid=0, busy=0 and counter=0.
REQ-024 Asserting reset mid-scan or in DONE SHALL discard the partial or undelivered frame with no valid pulse.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is seen high.

Configuration
REQ-026 With the macro SCAN_PARITY_EN defined, the block SHALL add output port parity (1 bit), loaded together with data as the XOR of all NUM_CH captured bits, reset to 0 and held with data.
REQ-027 With SCAN_PARITY_EN undefined, the parity port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Defaults; bench mux model y=P[select] with P=13'h0A69; start pulse, ready=1 -> valid high for 1 cycle exactly 26 cycles after start, data=13'h0A69, select sequence 0..12.
REQ-029 SETTLE=0, P=13'h1FFF -> valid after 13 cycles, data=13'h1FFF; change P to 13'h0000 and rescan -> data=13'h0000.
REQ-030 ready=0 for 10 cycles after valid -> valid and data held, busy=1, and a start pulse during DONE is ignored; raise ready -> IDLE next cycle, no second frame.
REQ-031 Assert rst_n=0 when select=6 -> all outputs are 0 immediately; after release, a new start produces a full correct frame, data=13'h0A69.
REQ-032 SCAN_PARITY_EN defined: P=13'h0A69 -> parity=0; P=13'h0A68 -> parity=1; undefined: compile without the parity port succeeds.
REQ-033 start held high continuously with ready=1 -> back-to-back frames, each separated by one IDLE cycle, and no select value exceeds 12.

Source files
------------

// File: rtl/mux_scan_if.sv
// Frame-capture handshake and mux bus between the scan controller and its environment.
// The parity wire and modport members exist only when SCAN_PARITY_EN is defined.
interface mux_scan_if #(
    parameter int NUM_CH = 13
) ();
    logic              start;
    logic              y;
    logic [3:0]        select;
    logic [NUM_CH-1:0] data;
    logic              valid;
    logic              ready;
    logic              busy;
`ifdef SCAN_PARITY_EN
    logic              parity;
`endif

`ifdef SCAN_PARITY_EN
    modport master (
        output start, y, ready,
        input  select, data, valid, busy, parity
    );
    modport slave (
        input  start, y, ready,
        output select, data, valid, busy, parity
    );
`else
    modport master (
        output start, y, ready,
        input  select, data, valid, busy
    );
    modport slave (
        input  start, y, ready,
        output select, data, valid, busy
    );
`endif
endinterface

// File: rtl/mux_scan_capture.sv
// Scans an external N:1 mux one channel at a time and captures a full frame of its outputs.
// Optional frame parity output enabled by defining SCAN_PARITY_EN.
module mux_scan_capture #(
    parameter int NUM_CH = 13,
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_scan_if.slave  bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] LAST_CH     = 4'(NUM_CH - 1);
    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    // With no settle time the controller samples every cycle and never visits S_SETTLE.
    localparam logic [1:0] S_AFTER_SELECT = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;

    logic [1:0]        state_reg,  state_next;
    logic [3:0]        select_reg, select_next;
    logic [3:0]        cnt_reg,    cnt_next;
    logic [NUM_CH-1:0] shadow_reg, shadow_next;
    logic [NUM_CH-1:0] data_reg,   data_next;
    logic              valid_reg,  valid_next;
    logic              busy_reg,   busy_next;

    // Shadow image with the currently selected bit replaced by the live mux output.
    logic [NUM_CH-1:0] shadow_sampled;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_shadow_bit
            assign shadow_sampled[gi] = (select_reg == 4'(gi)) ? bus.y : shadow_reg[gi];
        end
    endgenerate

`ifdef SCAN_PARITY_EN
    logic parity_reg, parity_next;
    logic frame_parity;

    assign frame_parity = ^shadow_sampled;
`endif

    always_comb begin
        state_next  = state_reg;
        select_next = select_reg;
        cnt_next    = cnt_reg;
        shadow_next = shadow_reg;
        data_next   = data_reg;
        valid_next  = valid_reg;
        busy_next   = busy_reg;
`ifdef SCAN_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next  = S_AFTER_SELECT;
                    select_next = 4'd0;
                    cnt_next    = 4'd0;
                    shadow_next = '0;
                    busy_next   = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_reg == SETTLE_LAST) begin
                    cnt_next   = 4'd0;
                    state_next = S_SAMPLE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            S_SAMPLE: begin
                shadow_next = shadow_sampled;
                if (select_reg == LAST_CH) begin
                    data_next  = shadow_sampled;
                    valid_next = 1'b1;
                    state_next = S_DONE;
`ifdef SCAN_PARITY_EN
                    parity_next = frame_parity;
`endif
                end else begin
                    select_next = select_reg + 4'd1;
                    cnt_next    = 4'd0;
                    state_next  = S_AFTER_SELECT;
                end
            end
            S_DONE: begin
                // start is deliberately not examined here, even on the handshake edge.
                if (valid_reg && bus.ready) begin
                    valid_next  = 1'b0;
                    busy_next   = 1'b0;
                    select_next = 4'd0;
                    state_next  = S_IDLE;
                end
            end
            default: begin
                state_next  = S_IDLE;
                select_next = 4'd0;
                cnt_next    = 4'd0;
                valid_next  = 1'b0;
                busy_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            select_reg <= 4'd0;
            cnt_reg    <= 4'd0;
            shadow_reg <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            select_reg <= select_next;
            cnt_reg    <= cnt_next;
            shadow_reg <= shadow_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            busy_reg   <= busy_next;
        end
    end

`ifdef SCAN_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end

    assign bus.parity = parity_reg;
`endif

    assign bus.select = select_reg;
    assign bus.data   = data_reg;
    assign bus.valid  = valid_reg;
    assign bus.busy   = busy_reg;

endmodule
